// File: rtl/uart_frame_parser.sv
// Framed-command parser behind the UART receiver: SYNC, LEN, payload, CSUM.
// Writes payload bytes to an external buffer and flags each frame good or bad.
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         ADDR_W       = 4,
  parameter int         TIMEOUT_CLKS = 12000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_byte,
  input  logic              byte_available,
  output logic [ADDR_W-1:0] pay_addr,
  output logic [7:0]        pay_data,
  output logic              pay_we,
  output logic [7:0]        frame_len,
  output logic              frame_valid,
  output logic              frame_error,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam logic [1:0] S_SYNC    = 2'd0;
  localparam logic [1:0] S_LEN     = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_CSUM    = 2'd3;

  localparam int         TW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  logic [1:0]        state_q, state_d;
  logic              avail_q, avail_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [ADDR_W-1:0] pay_addr_q, pay_addr_d;
  logic [7:0]        pay_data_q, pay_data_d;
  logic              pay_we_q, pay_we_d;
  logic [7:0]        frame_len_q, frame_len_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_error_q, frame_error_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              busy_q, busy_d;
  logic              strobe;

  assign strobe = byte_available & ~avail_q;

  always_comb begin
    state_d       = state_q;
    avail_d       = byte_available;
    idx_d         = idx_q;
    sum_d         = sum_q;
    tmo_d         = '0;
    pay_addr_d    = pay_addr_q;
    pay_data_d    = pay_data_q;
    pay_we_d      = 1'b0;
    frame_len_d   = frame_len_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    err_code_d    = err_code_q;

    if (state_q != S_SYNC && !strobe) begin
      tmo_d = tmo_q + TW'(1);
    end

    case (state_q)
      S_SYNC: begin
        if (strobe && rx_byte == SYNC_BYTE) begin
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (strobe) begin
          frame_len_d = rx_byte;
          sum_d       = rx_byte;
          idx_d       = 8'd0;
          if (rx_byte != 8'd0 && rx_byte <= MAX_LEN8) begin
            state_d = S_PAYLOAD;
          end else begin
            frame_error_d = 1'b1;
            err_code_d    = 2'd1;
            state_d       = S_SYNC;
          end
        end
      end
      S_PAYLOAD: begin
        if (strobe) begin
          pay_we_d   = 1'b1;
          pay_data_d = rx_byte;
          pay_addr_d = idx_q[ADDR_W-1:0];
          sum_d      = sum_q + rx_byte;
          idx_d      = idx_q + 8'd1;
          if (idx_q == frame_len_q - 8'd1) begin
            state_d = S_CSUM;
          end
        end
      end
      default: begin
        if (strobe) begin
          if (rx_byte == sum_q) begin
            frame_valid_d = 1'b1;
            err_code_d    = 2'd0;
          end else begin
            frame_error_d = 1'b1;
            err_code_d    = 2'd2;
          end
          state_d = S_SYNC;
        end
      end
    endcase

    // A strobe arriving on the last allowed cycle is processed instead.
    if (state_q != S_SYNC && !strobe && tmo_q == TMO_LAST) begin
      frame_error_d = 1'b1;
      err_code_d    = 2'd3;
      state_d       = S_SYNC;
      tmo_d         = '0;
    end

    busy_d = (state_d != S_SYNC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_SYNC;
      avail_q       <= 1'b1;
      idx_q         <= 8'd0;
      sum_q         <= 8'd0;
      tmo_q         <= '0;
      pay_addr_q    <= '0;
      pay_data_q    <= 8'd0;
      pay_we_q      <= 1'b0;
      frame_len_q   <= 8'd0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      err_code_q    <= 2'd0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      avail_q       <= avail_d;
      idx_q         <= idx_d;
      sum_q         <= sum_d;
      tmo_q         <= tmo_d;
      pay_addr_q    <= pay_addr_d;
      pay_data_q    <= pay_data_d;
      pay_we_q      <= pay_we_d;
      frame_len_q   <= frame_len_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      err_code_q    <= err_code_d;
      busy_q        <= busy_d;
    end
  end

  assign pay_addr    = pay_addr_q;
  assign pay_data    = pay_data_q;
  assign pay_we      = pay_we_q;
  assign frame_len   = frame_len_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign err_code    = err_code_q;
  assign busy        = busy_q;

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART receiver on the 12 MHz icestick clock.
- Consumes received bytes, locates framed command packets, and writes payload bytes into an external buffer.
- Packet format: SYNC, LEN, LEN payload bytes, CSUM.
- Signals each packet as accepted (frame_valid) or rejected (frame_error), with an error code.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, largest legal payload length (1..MAX_LEN).
- ADDR_W, 4, payload buffer address width; 2**ADDR_W >= MAX_LEN.
- TIMEOUT_CLKS, 12000, maximum clocks between bytes inside a frame (1 ms at 12 MHz).

Ports:
- clk  input  1  system clock, 12 MHz.
- rst  input  1  synchronous, active-high reset.
- rx_byte  input  8  received byte; valid while byte_available is high.
- byte_available  input  1  level from the receiver; high for one or more cycles per byte.
- pay_addr  output  ADDR_W  payload buffer write address (0 = first payload byte).
- pay_data  output  8  payload buffer write data.
- pay_we  output  1  one-cycle payload write strobe.
- frame_len  output  8  LEN of the frame in progress or last frame; held until the next LEN byte.
- frame_valid  output  1  one-cycle pulse: frame accepted.
- frame_error  output  1  one-cycle pulse: frame rejected.
- err_code  output  2  0 none, 1 bad length, 2 bad checksum, 3 timeout; held until the next frame_valid/frame_error.
- busy  output  1  high whenever state != S_SYNC.

Behaviour:
- Byte strobe:
  - Internal register avail_q <= byte_available.
  - strobe = byte_available & ~avail_q. Exactly one strobe per byte regardless of level width.
- Reset:
  - Clears state to S_SYNC; clears pay_addr, pay_data, pay_we, frame_len, frame_valid, frame_error, err_code, busy, the checksum accumulator and the timeout counter.
  - Loads avail_q with 1, so a byte_available level already high at reset release is not accepted.
  - Reset mid-frame discards the frame silently: no pulses, no writes.
- All outputs are registered. Every response (write or pulse) appears the cycle after the strobe that caused it.
- S_SYNC:
  - strobe with rx_byte == SYNC_BYTE -> S_LEN.
  - Any other byte is ignored; stay in S_SYNC.
- S_LEN:
  - On strobe, capture frame_len <= rx_byte and sum <= rx_byte.
  - If 1 <= rx_byte <= MAX_LEN: -> S_PAYLOAD with payload index 0.
  - Else: frame_error pulse, err_code = 1, -> S_SYNC.
- S_PAYLOAD:
  - On strobe, pay_we = 1, pay_data = rx_byte, pay_addr = index.
  - sum <= sum + rx_byte, mod 256, 8-bit wrap.
  - index increments; after byte LEN-1 -> S_CSUM.
  - A byte equal to SYNC_BYTE is treated as ordinary data (no resync).
- S_CSUM:
  - On strobe, if rx_byte == sum: frame_valid pulse, err_code = 0.
  - Else: frame_error pulse, err_code = 2.
  - Either way -> S_SYNC.
- Timeout:
  - Counter runs in every state except S_SYNC and clears on each strobe.
  - On reaching TIMEOUT_CLKS without a strobe: frame_error pulse, err_code = 3, -> S_SYNC.
  - Strobe in the same cycle the limit is reached: the strobe wins, the byte is processed and the counter clears.
- frame_valid and frame_error are never high together.
- pay_we never asserts outside S_PAYLOAD.
- Payload bytes already written by a rejected frame stay in the buffer. Consumers use only data signalled by frame_valid.
- A new SYNC may follow a completed or aborted frame immediately (next strobe).

Test Plan:
- Good frame: A5,02,10,20,32 -> writes (0,0x10),(1,0x20); frame_valid once; frame_len = 2; err_code = 0.
- Bad checksum: A5,02,10,20,33 -> two writes, then frame_error, err_code = 2, state back to S_SYNC, busy = 0.
- Bad length: A5,00 and separately A5,11 (MAX_LEN = 16) -> frame_error, err_code = 1, no pay_we.
- Leading garbage and stretched strobes: 00,FF,A5,01,A5,A6, each with byte_available held 5 cycles -> exactly one write (0,0xA5); frame_valid (sum 0x01+0xA5 = 0xA6).
- Timeout: A5,03,11, then idle for TIMEOUT_CLKS -> frame_error, err_code = 3. A following A5,01,7E,7F -> frame_valid.
- Reset mid-frame: assert rst after A5,04,01 with byte_available high through release -> no pulses, busy = 0, first post-reset byte is not accepted until byte_available toggles.
